pipelined_adder_tree: RTL and testbench



---
 rtl/pipelined_adder_tree.sv | 177 +++++++++++++++++
 tb/tb_pipelined_adder_tree.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with optional group accumulation.
// An input register feeds LAYER_NUM tree layers; stage A either passes the sum through or accumulates it.
module pipelined_adder_tree #(
  parameter int INPUT_BW   = 8,
  parameter int LAYER_NUM  = 3,
  parameter int ARRAY_SIZE = 8,
  parameter int ACC_BW     = 16,
  parameter int CNT_BW     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] operands,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic                                acc_mode,
  output logic signed [ACC_BW-1:0]            result,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_overflow,
  output logic [CNT_BW-1:0]                   out_count
);

  localparam int SUM_W = INPUT_BW + LAYER_NUM;

  logic                                advance_s;
  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0] opnd_q;
  logic [2:0]                          side0_q;

  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic [CNT_BW-1:0]        cnt_q, cnt_d;
  logic                     sticky_q, sticky_d;
  logic signed [ACC_BW-1:0] result_q, result_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_ovf_q, out_ovf_d;
  logic [CNT_BW-1:0]        out_cnt_q, out_cnt_d;

  // Every stage shares one load enable, so a held output freezes the whole pipe.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;

  // Sideband bits are packed as {valid, acc_mode, last}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q  <= '0;
      side0_q <= 3'b000;
    end else if (advance_s) begin
      opnd_q  <= operands;
      side0_q <= {in_valid, acc_mode, in_last};
    end
  end

  for (genvar l = 1; l <= LAYER_NUM; l++) begin : g_layer
    localparam int W = INPUT_BW + l;
    localparam int N = ARRAY_SIZE >> l;

    logic [2:0] side_d;
    logic [2:0] side_q;

    if (l == 1) begin : g_src
      assign side_d = side0_q;
    end else begin : g_src
      assign side_d = g_layer[l-1].side_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        side_q <= 3'b000;
      end else if (advance_s) begin
        side_q <= side_d;
      end
    end

    for (genvar j = 0; j < N; j++) begin : g_node
      logic [W-2:0]        a_s;
      logic [W-2:0]        b_s;
      logic signed [W-1:0] sum_d;
      logic signed [W-1:0] sum_q;

      if (l == 1) begin : g_in
        assign a_s = opnd_q[2*j];
        assign b_s = opnd_q[2*j+1];
      end else begin : g_in
        assign a_s = g_layer[l-1].g_node[2*j].sum_q;
        assign b_s = g_layer[l-1].g_node[2*j+1].sum_q;
      end

      // One bit of sign extension per layer keeps every partial sum exact.
      assign sum_d = {a_s[W-2], a_s} + {b_s[W-2], b_s};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q <= '0;
        end else if (advance_s) begin
          sum_q <= sum_d;
        end
      end
    end
  end

  logic signed [SUM_W-1:0]  tree_sum_s;
  logic signed [ACC_BW-1:0] sum_ext_s;
  logic signed [ACC_BW-1:0] acc_sum_s;
  logic                     acc_ovf_s;
  logic [CNT_BW-1:0]        cnt_inc_s;
  logic                     a_vld_s, a_mode_s, a_last_s;

  assign tree_sum_s = g_layer[LAYER_NUM].g_node[0].sum_q;
  assign sum_ext_s  = ACC_BW'(tree_sum_s);
  assign {a_vld_s, a_mode_s, a_last_s} = g_layer[LAYER_NUM].side_q;
  assign acc_sum_s  = acc_q + sum_ext_s;
  assign acc_ovf_s  = (acc_q[ACC_BW-1] == sum_ext_s[ACC_BW-1]) &&
                      (acc_sum_s[ACC_BW-1] != acc_q[ACC_BW-1]);
  assign cnt_inc_s  = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_BW-1){1'b0}}, 1'b1};

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;
    if (advance_s) begin
      out_valid_d = 1'b0;
      if (a_vld_s && !a_mode_s) begin
        // Pass-through leaves any open group untouched.
        result_d    = sum_ext_s;
        out_cnt_d   = {{(CNT_BW-1){1'b0}}, 1'b1};
        out_ovf_d   = 1'b0;
        out_valid_d = 1'b1;
      end else if (a_vld_s && a_last_s) begin
        result_d    = acc_sum_s;
        out_cnt_d   = cnt_inc_s;
        out_ovf_d   = sticky_q | acc_ovf_s;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        sticky_d    = 1'b0;
      end else if (a_vld_s) begin
        acc_d    = acc_sum_s;
        cnt_d    = cnt_inc_s;
        sticky_d = sticky_q | acc_ovf_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign result       = result_q;
  assign out_valid    = out_valid_q;
  assign out_overflow = out_ovf_q;
  assign out_count    = out_cnt_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: pass-through, accumulate, overflow, stall and reset cases.
module tb_pipelined_adder_tree;

  typedef logic [7:0][7:0] ops_t;
  typedef struct {
    int res;
    int cnt;
    int ovf;
    int cyc;
  } obs_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  ops_t                operands = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                in_last = 1'b0;
  logic                acc_mode = 1'b0;
  logic signed [15:0]  result;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic                out_overflow;
  logic [7:0]          out_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  obs_t q[$];

  pipelined_adder_tree dut (
    .clk(clk), .rst(rst), .operands(operands), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .acc_mode(acc_mode), .result(result), .out_valid(out_valid),
    .out_ready(out_ready), .out_overflow(out_overflow), .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every transferred result; the transfer happens at the following rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q.push_back('{int'(result), int'(out_count), int'(out_overflow), cyc});
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic ops_t ops_const(input logic [7:0] v);
    ops_t o;
    for (int i = 0; i < 8; i++) o[i] = v;
    return o;
  endfunction

  function automatic ops_t ops_seq();
    ops_t o;
    for (int i = 0; i < 8; i++) o[i] = 8'(i + 1);
    return o;
  endfunction

  task automatic send(input ops_t ops, input logic mode, input logic last);
    bit ok = 1'b0;
    operands = ops;
    acc_mode = mode;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int t = 0; t < 200 && q.size() < n; t++) tick();
    repeat (6) tick();
    chk(tag, q.size(), n);
  endtask

  task automatic chk_out(input string tag, input int i, input int res, input int cnt, input int ovf);
    if (q.size() > i) begin
      chk({tag, "_res"}, q[i].res, res);
      chk({tag, "_cnt"}, q[i].cnt, cnt);
      chk({tag, "_ovf"}, q[i].ovf, ovf);
    end else begin
      chk({tag, "_present"}, q.size(), i + 1);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_result", result, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_count", out_count, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Latency: out_valid must rise exactly 4 edges after acceptance.
    send(ops_const(8'h7F), 1'b0, 1'b0);
    begin
      int seen = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = cyc;
          break;
        end
      end
      chk("latency", seen - acc_cyc, 4);
    end
    wait_results("lat_n", 1);
    chk_out("pos127", 0, 1016, 1, 0);
    q.delete();

    send(ops_const(8'h80), 1'b0, 1'b0);
    wait_results("neg128_n", 1);
    chk_out("neg128", 0, -1024, 1, 0);
    q.delete();

    send(ops_seq(), 1'b0, 1'b0);
    send(ops_const(8'h7F), 1'b0, 1'b0);
    send(ops_const(8'h80), 1'b0, 1'b0);
    wait_results("b2b_n", 3);
    chk_out("b2b0", 0, 36, 1, 0);
    chk_out("b2b1", 1, 1016, 1, 0);
    chk_out("b2b2", 2, -1024, 1, 0);
    if (q.size() == 3) begin
      chk("b2b_gap01", q[1].cyc - q[0].cyc, 1);
      chk("b2b_gap12", q[2].cyc - q[1].cyc, 1);
    end
    q.delete();

    for (int b = 0; b < 3; b++) send(ops_seq(), 1'b1, b == 2);
    wait_results("acc3_n", 1);
    chk_out("acc3", 0, 108, 3, 0);
    q.delete();

    for (int b = 0; b < 33; b++) send(ops_const(8'h7F), 1'b1, b == 32);
    wait_results("acc33_n", 1);
    chk_out("acc33", 0, -32008, 33, 1);
    q.delete();

    send(ops_seq(), 1'b1, 1'b1);
    wait_results("single_n", 1);
    chk_out("single", 0, 36, 1, 0);
    q.delete();

    // Overflow on beat 33, none on beat 34: the flag must stay set.
    for (int b = 0; b < 34; b++) send(ops_const(8'h7F), 1'b1, b == 33);
    wait_results("acc34_n", 1);
    chk_out("acc34", 0, -30992, 34, 1);
    q.delete();

    fork
      begin
        for (int k = 1; k <= 6; k++) send(ops_const(8'(k)), 1'b0, 1'b0);
      end
      begin
        for (int t = 0; t < 50; t++) begin
          tick();
          if (out_valid) break;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_hold", result, 8);
        end
        tick();
        out_ready = 1'b1;
      end
    join
    wait_results("stall_n", 6);
    for (int k = 0; k < 6; k++) chk_out("stall_seq", k, 8 * (k + 1), 1, 0);
    q.delete();

    send(ops_seq(), 1'b1, 1'b0);
    send(ops_const(8'h7F), 1'b0, 1'b0);
    send(ops_seq(), 1'b1, 1'b1);
    wait_results("inter_n", 2);
    chk_out("inter_pass", 0, 1016, 1, 0);
    chk_out("inter_grp", 1, 72, 2, 0);
    q.delete();

    send(ops_const(8'h7F), 1'b0, 1'b0);
    send(ops_seq(), 1'b1, 1'b0);
    send(ops_seq(), 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    q.delete();
    send(ops_seq(), 1'b1, 1'b1);
    wait_results("post_rst_n", 1);
    chk_out("post_rst", 0, 36, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
